// File: rtl/lfsr_pkg.sv
// Shared mode constants and the maximal-length tap table for the LFSR family.
// Tap masks are in state-bit form: bit i set means state[i] participates.
`timescale 1ns/1ps
package lfsr_pkg;

    localparam bit FIB   = 1'b0;
    localparam bit GAL   = 1'b1;
    localparam bit DIR_R = 1'b1;
    localparam bit DIR_L = 1'b0;

    // Maximal-length masks, listed as (tap-1) bit positions of the classic tap tables
    function automatic logic [31:0] max_taps(input int width);
        logic [31:0] m;
        case (width)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: current state -> next state and the serial bit it shifts out.
// Shared with the PRBS checker so both sides always agree on the polynomial form.
`timescale 1ns/1ps
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(max_taps(WIDTH)),
    parameter bit              GALOIS      = FIB,
    parameter bit              SHIFT_RIGHT = DIR_R
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bit_o
);

    generate
        if (GALOIS == GAL) begin : g_gal
            if (SHIFT_RIGHT == DIR_R) begin : g_right
                assign bit_o  = state_i[0];
                assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
            end else begin : g_left
                assign bit_o  = state_i[WIDTH-1];
                assign next_o = (state_i << 1) ^ (state_i[WIDTH-1] ? TAPS : '0);
            end
        end else begin : g_fib
            logic fb;
            assign fb = ^(state_i & TAPS);
            if (SHIFT_RIGHT == DIR_R) begin : g_right
                assign bit_o  = state_i[0];
                assign next_o = {fb, state_i[WIDTH-1:1]};
            end else begin : g_left
                assign bit_o  = state_i[WIDTH-1];
                assign next_o = {state_i[WIDTH-2:0], fb};
            end
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with enable, runtime load, all-zero lockup recovery and
// on-line period measurement against the most recent seed/load reference.
`timescale 1ns/1ps
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(max_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(32'h49),
    parameter bit               GALOIS      = FIB,
    parameter bit               SHIFT_RIGHT = DIR_R
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q,   ref_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q,   wrap_d;
    logic [WIDTH-1:0] step_next;

    lfsr_next #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .GALOIS      (GALOIS),
        .SHIFT_RIGHT (SHIFT_RIGHT)
    ) u_next (
        .state_i (state_q),
        .next_o  (step_next),
        .bit_o   (bit_out)
    );

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            state_d = load_val;
            ref_d   = load_val;
            cnt_d   = '0;
        end else if (en) begin
            if (state_q == '0) begin
                // The all-zero state is a fixed point; restart from SEED as a fresh measurement
                state_d  = SEED;
                ref_d    = SEED;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else begin
                state_d = step_next;
                if (step_next == ref_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_q + WIDTH'(1);
                    cnt_d    = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign lfsr_out = state_q;
    assign lockup   = lockup_q;
    assign wrap     = wrap_q;
    assign period   = period_q;

endmodule
